// File: rtl/memory_sequencer_if.sv
// Client command/response bus of the memory sequencer.
// The client (CPU or loader) is the master; the sequencer is the slave.
interface memory_sequencer_if #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16,
    parameter int LenWidth  = 8
) ();
    logic                 Req;
    logic                 Ready;
    logic                 Cmd_Write;
    logic [AddrWidth-1:0] Cmd_Addr;
    logic [LenWidth-1:0]  Cmd_Len;
    logic [DataWidth-1:0] Cmd_Data;
    logic [DataWidth-1:0] Rd_Data;
    logic                 Rd_Valid;
    logic                 Done;
    logic                 Busy;

    modport master (
        output Req, Cmd_Write, Cmd_Addr, Cmd_Len, Cmd_Data,
        input  Ready, Rd_Data, Rd_Valid, Done, Busy
    );

    modport slave (
        input  Req, Cmd_Write, Cmd_Addr, Cmd_Len, Cmd_Data,
        output Ready, Rd_Data, Rd_Valid, Done, Busy
    );
endinterface

// File: rtl/memory_sequencer.sv
// Burst read/fill sequencer for a single-port negedge BRAM.
// Control outputs change on posedge only, so the memory sees stable
// enables, address and data at its negedge; that half-cycle offset lets
// a read word be captured on the very next posedge, giving 1 word/cycle.
module memory_sequencer #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16,
    parameter int LenWidth  = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    memory_sequencer_if.slave    cmd,
    output logic [AddrWidth-1:0] Mem_Address,
    output logic [DataWidth-1:0] Mem_DIn,
    output logic                 Mem_En,
    output logic                 Mem_Write_EN,
    input  logic [DataWidth-1:0] Mem_DOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] din_q, din_d;
    logic [LenWidth-1:0]  count_q, count_d;
    logic                 mem_en_q, mem_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    // Only Ready is combinational: it must drop immediately under Reset.
    assign cmd.Ready    = (state_q == IDLE) & ~Reset;
    assign cmd.Rd_Data  = rd_data_q;
    assign cmd.Rd_Valid = rd_valid_q;
    assign cmd.Done     = done_q;
    assign cmd.Busy     = busy_q;
    assign Mem_Address  = addr_q;
    assign Mem_DIn      = din_q;
    assign Mem_En       = mem_en_q;
    assign Mem_Write_EN = wr_en_q;

    // Next-state and registered-output logic; strobes default low each cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        count_d    = count_q;
        mem_en_d   = mem_en_q;
        wr_en_d    = wr_en_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_en_d = 1'b1;
                wr_en_d  = 1'b1;
                if (cmd.Req) begin
                    // Command fields are captured only here; the enables go
                    // low now so the memory acts on the following negedge.
                    addr_d   = cmd.Cmd_Addr;
                    din_d    = cmd.Cmd_Data;
                    count_d  = cmd.Cmd_Len;
                    mem_en_d = 1'b0;
                    wr_en_d  = ~cmd.Cmd_Write;
                    state_d  = cmd.Cmd_Write ? WRITE : READ;
                end
            end
            READ: begin
                // DOut was produced by the negedge in the middle of this beat.
                rd_data_d  = Mem_DOut;
                rd_valid_d = 1'b1;
                if (count_q != '0) begin
                    addr_d  = addr_q + AddrWidth'(1);
                    count_d = count_q - LenWidth'(1);
                end else begin
                    mem_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            WRITE: begin
                if (count_q != '0) begin
                    addr_d  = addr_q + AddrWidth'(1);
                    count_d = count_q - LenWidth'(1);
                end else begin
                    mem_en_d = 1'b1;
                    wr_en_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                mem_en_d = 1'b1;
                wr_en_d  = 1'b1;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            count_q    <= '0;
            mem_en_q   <= 1'b1;
            wr_en_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            count_q    <= count_d;
            mem_en_q   <= mem_en_d;
            wr_en_q    <= wr_en_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer with a behavioural 256x16 negedge BRAM.
module tb_memory_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_dout;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        mem_init_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int en_low_cnt = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;
    exp_t sb [$];

    memory_sequencer_if bus ();

    memory_sequencer dut (
        .Clk         (clk),
        .Reset       (reset),
        .cmd         (bus),
        .Mem_Address (mem_addr),
        .Mem_DIn     (mem_din),
        .Mem_En      (mem_en),
        .Mem_Write_EN(mem_we),
        .Mem_DOut    (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input int i);
        case (i)
            8'h10:   return 16'hABCD;
            8'hFE:   return 16'h1111;
            8'hFF:   return 16'h2222;
            8'h00:   return 16'h3333;
            default: return 16'(i * 16'h0101) ^ 16'h8421;
        endcase
    endfunction

    // Negedge single-port BRAM: active-low enable and write enable.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_init_done <= 1'b1;
        end else if (!mem_en) begin
            if (!mem_we) mem[mem_addr] <= mem_din;
            else         mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: scoreboard for read beats plus the enable invariant.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_en === 1'b1) chk("we_high_when_disabled", mem_we, 1'b1);
            if (mem_en === 1'b0) en_low_cnt++;
            if (bus.Rd_Valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_data", bus.Rd_Data, e.d);
                    chk("rd_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] len,
                         input logic [15:0] d, input int npush);
        int guard = 0;
        while (bus.Ready !== 1'b1 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready_before_issue", bus.Ready, 1'b1);
        bus.Req       = 1'b1;
        bus.Cmd_Write = w;
        bus.Cmd_Addr  = a;
        bus.Cmd_Len   = len;
        bus.Cmd_Data  = d;
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        acc_cyc = cyc;
        if (!w) begin
            for (int i = 0; i < npush; i++) begin
                exp_t e;
                e.d = ref_mem[8'(a + 8'(i))];
                e.c = acc_cyc + 1 + i;
                sb.push_back(e);
            end
        end else begin
            for (int i = 0; i <= int'(len); i++) ref_mem[8'(a + 8'(i))] = d;
        end
    endtask

    task automatic wait_done(input int exp_lat, input logic exp_rv);
        int n = 0;
        logic seen = 1'b0;
        while (n < 400 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            chk("done_latency", cyc - acc_cyc, exp_lat);
            chk("rd_valid_with_done", bus.Rd_Valid, exp_rv);
        end else begin
            chk("done_timeout", 1'b0, 1'b1);
        end
    endtask

    initial begin
        int e0;
        int acc1;
        int ndone;
        int nmis;
        int guard;

        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        reset         = 1'b1;
        bus.Req       = 1'b0;
        bus.Cmd_Write = 1'b0;
        bus.Cmd_Addr  = '0;
        bus.Cmd_Len   = '0;
        bus.Cmd_Data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.Ready, 1'b0);
        chk("rst_mem_en", mem_en, 1'b1);
        chk("rst_mem_we", mem_we, 1'b1);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_din", mem_din, 16'h0000);
        chk("rst_rd_data", bus.Rd_Data, 16'h0000);
        chk("rst_rd_valid", bus.Rd_Valid, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_busy", bus.Busy, 1'b0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", bus.Ready, 1'b1);
        @(posedge clk);
        #1;

        // Single read of 0x10
        e0 = en_low_cnt;
        issue(1'b0, 8'h10, 8'd0, 16'h0000, 1);
        chk("single_busy", bus.Busy, 1'b1);
        chk("single_ready_low", bus.Ready, 1'b0);
        wait_done(1, 1'b1);
        chk("single_rd_data", bus.Rd_Data, 16'hABCD);
        chk("single_en_cycles", en_low_cnt - e0, 1);
        chk("single_busy_after", bus.Busy, 1'b0);

        // Fill burst 0x20..0x23
        e0 = en_low_cnt;
        issue(1'b1, 8'h20, 8'd3, 16'h5A5A, 0);
        wait_done(4, 1'b0);
        chk("fill_en_cycles", en_low_cnt - e0, 4);
        @(posedge clk);
        #1;
        chk("fill_below", mem[8'h1F], pat(8'h1F));
        chk("fill_first", mem[8'h20], 16'h5A5A);
        chk("fill_last", mem[8'h23], 16'h5A5A);
        chk("fill_above", mem[8'h24], pat(8'h24));

        // Wrapping read 0xFE, 0xFF, 0x00
        issue(1'b0, 8'hFE, 8'd2, 16'h0000, 3);
        wait_done(3, 1'b1);
        chk("wrap_last_data", bus.Rd_Data, 16'h3333);

        // Read back the filled words
        issue(1'b0, 8'h1F, 8'd5, 16'h0000, 6);
        wait_done(6, 1'b1);

        // Back-to-back: second command held during a busy Len=3 read
        e0 = en_low_cnt;
        issue(1'b0, 8'h30, 8'd3, 16'h0000, 4);
        acc1 = acc_cyc;
        bus.Req       = 1'b1;
        bus.Cmd_Write = 1'b0;
        bus.Cmd_Addr  = 8'h50;
        bus.Cmd_Len   = 8'd1;
        guard = 0;
        while (bus.Ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("b2b_gap_en", mem_en, 1'b1);
        chk("b2b_gap_done", bus.Done, 1'b1);
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        acc_cyc = cyc;
        chk("b2b_accept_cycle", acc_cyc - acc1, 5);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e.d = ref_mem[8'h50 + i];
            e.c = acc_cyc + 1 + i;
            sb.push_back(e);
        end
        wait_done(2, 1'b1);
        chk("b2b_en_cycles", en_low_cnt - e0, 6);

        // Reset in the middle of a Len=7 read
        issue(1'b0, 8'h40, 8'd7, 16'h0000, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ready_low", bus.Ready, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_mem_en", mem_en, 1'b1);
        chk("midrst_mem_we", mem_we, 1'b1);
        chk("midrst_rd_valid", bus.Rd_Valid, 1'b0);
        chk("midrst_done", bus.Done, 1'b0);
        chk("midrst_busy", bus.Busy, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_high", bus.Ready, 1'b1);
        ndone = 0;
        e0 = en_low_cnt;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_no_enable", en_low_cnt - e0, 0);

        // Final memory image and scoreboard drain
        nmis = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
        chk("mem_image_mismatches", nmis, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case a wait above misbehaves.
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
